// File: rtl/adam_uart_pkg.sv
// Shared UART types and constants for the Zybo receive path (and the future transmitter).
package adam_uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_rx_state_t;

endpackage

// File: rtl/adam_sync_2ff.sv
// Single-bit two-flop synchronizer with a selectable reset value.
module adam_sync_2ff #(
    parameter logic ResetValue = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adam_zybo_uart_rx.sv
// UART 8N1 receiver: deserializes the adam_zybo uart_tx line into a valid/ready byte stream,
// flagging framing errors and overruns as single-cycle pulses.
module adam_zybo_uart_rx
    import adam_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1085
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [2:0]      IdxLast = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t            state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      stop_ok_q, stop_ok_d;
    logic                      stop_bad_q, stop_bad_d;

    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
    adam_sync_2ff #(
        .ResetValue (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        stop_ok_d  = 1'b0;
        stop_bad_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == CntFull) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                if (cnt_q == CntFull) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        stop_ok_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        stop_bad_d = 1'b1;
                        state_d    = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StBreak: begin
                // A held-low line must return high before a new start is accepted.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Delivery happens one cycle after the stop sample; sh is untouched until the next DATA.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (stop_ok_q) begin
            if (!valid_q || ready_i) begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            stop_ok_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            stop_ok_q   <= stop_ok_d;
            stop_bad_q  <= stop_bad_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_adam_zybo_uart_rx.sv
// Directed bench for adam_zybo_uart_rx at 16 clocks per bit.
module tb_adam_zybo_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int first_rise = -1;
    logic valid_prev = 1'b0;
    logic [7:0] rxq[$];

    adam_zybo_uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) rxq.push_back(data_o);
            if (frame_err_o) fe_cnt = fe_cnt + 1;
            if (overrun_o) ov_cnt = ov_cnt + 1;
            if (valid_o && !valid_prev && first_rise < 0) first_rise = cyc;
        end
        valid_prev = valid_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1ns after a rising edge; rx is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_data"}, {24'd0, data_o}, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err_o}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun_o}, 32'd0);
    endtask

    int n;
    int lat;
    int fe_base;
    int ov_base;

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) sync_edge();

        // 1: two back-to-back bytes plus latency
        rxq.delete();
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        first_rise = -1;
        n = cyc;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (20) sync_edge();
        check("t1_count", rxq.size(), 2);
        if (rxq.size() >= 2) begin
            check("t1_byte0", {24'd0, rxq[0]}, 32'hA5);
            check("t1_byte1", {24'd0, rxq[1]}, 32'h3C);
        end
        lat = first_rise - n;
        check("t1_latency_in_window", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
        check("t1_ferr", fe_cnt - fe_base, 0);
        check("t1_ovr", ov_cnt - ov_base, 0);

        // 2: short low glitch on idle line
        rxq.delete();
        fe_base = fe_cnt;
        rx = 1'b0;
        repeat (4) sync_edge();
        rx = 1'b1;
        repeat (40) sync_edge();
        check("t2_no_valid", rxq.size(), 0);
        check("t2_no_ferr", fe_cnt - fe_base, 0);

        // 3: framing error, held break, then recovery
        rxq.delete();
        fe_base = fe_cnt;
        send_byte(8'h55, 1'b0);
        repeat (40) sync_edge();
        rx = 1'b1;
        repeat (10) sync_edge();
        check("t3_ferr_once", fe_cnt - fe_base, 1);
        check("t3_no_valid", rxq.size(), 0);
        send_byte(8'h01, 1'b1);
        repeat (20) sync_edge();
        check("t3_count", rxq.size(), 1);
        if (rxq.size() >= 1) check("t3_byte", {24'd0, rxq[0]}, 32'h01);
        check("t3_ferr_total", fe_cnt - fe_base, 1);

        // 4: overrun with consumer stalled
        ready_i = 1'b0;
        rxq.delete();
        ov_base = ov_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4) sync_edge();
        check("t4_data_held", {24'd0, data_o}, 32'h11);
        check("t4_valid_held", {31'd0, valid_o}, 32'd1);
        check("t4_ovr_once", ov_cnt - ov_base, 1);
        ready_i = 1'b1;
        sync_edge();
        check("t4_valid_cleared", {31'd0, valid_o}, 32'd0);
        check("t4_accepted", rxq.size(), 1);
        ready_i = 1'b0;

        // 5: handshake in the same cycle as the second delivery
        rxq.delete();
        ov_base = ov_cnt;
        send_byte(8'h11, 1'b1);
        repeat (4) sync_edge();
        n = cyc;
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                ready_i = 1'b1;
                sync_edge();
                check("t5_data_replaced", {24'd0, data_o}, 32'h22);
                check("t5_valid_kept", {31'd0, valid_o}, 32'd1);
                ready_i = 1'b0;
            end
        join
        repeat (4) sync_edge();
        check("t5_no_ovr", ov_cnt - ov_base, 0);
        check("t5_first_accepted", rxq.size(), 1);
        ready_i = 1'b1;
        repeat (4) sync_edge();

        // 6: reset mid-frame, then a clean byte
        rxq.delete();
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #1;
                rst = 1'b1;
                sync_edge();
                check_reset_outputs("t6_rst");
                rst = 1'b0;
            end
        join
        repeat (8) sync_edge();
        check("t6_no_partial", rxq.size(), 0);
        send_byte(8'h0F, 1'b1);
        repeat (20) sync_edge();
        check("t6_count", rxq.size(), 1);
        if (rxq.size() >= 1) check("t6_byte", {24'd0, rxq[0]}, 32'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
